// File: rtl/armaria_ctrl_pkg.sv
// Shared constants for the Armaria control path: instruction IDs, condition codes,
// sequencer state encoding and the ID classifier used by the sequencer.
package armaria_ctrl_pkg;

  localparam int ID_W  = 7;
  localparam int CNT_W = 8;

  localparam logic [ID_W-1:0] ID_ZERO   = 7'd0;
  localparam logic [ID_W-1:0] ID_MEM_LO = 7'd40;
  localparam logic [ID_W-1:0] ID_MEM_HI = 7'd55;
  localparam logic [ID_W-1:0] ID_MEM_X0 = 7'd67;
  localparam logic [ID_W-1:0] ID_MEM_X1 = 7'd68;
  localparam logic [ID_W-1:0] ID_INSW   = 7'd71;
  localparam logic [ID_W-1:0] ID_NOP    = 7'd74;
  localparam logic [ID_W-1:0] ID_HALT   = 7'd75;
  localparam logic [ID_W-1:0] ID_ILL_LO = 7'd76;
  localparam logic [ID_W-1:0] ID_ILL_HI = 7'd99;
  localparam logic [ID_W-1:0] ID_RESET  = 7'd100;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  typedef enum logic [2:0] {
    ST_RST      = 3'd0,
    ST_FETCH    = 3'd1,
    ST_EXEC     = 3'd2,
    ST_MEM_WAIT = 3'd3,
    ST_IO_WAIT  = 3'd4,
    ST_HALT     = 3'd5
  } seq_state_e;

  typedef enum logic [2:0] {
    CLS_ALU     = 3'd0,
    CLS_MEM     = 3'd1,
    CLS_IO      = 3'd2,
    CLS_HALT    = 3'd3,
    CLS_ILLEGAL = 3'd4
  } id_class_e;

  // ID 100 arriving from the decoder is an ordinary single-cycle instruction.
  function automatic id_class_e classify_id(input logic [ID_W-1:0] id);
    id_class_e cls;
    if (id == ID_ZERO) begin
      cls = CLS_ILLEGAL;
    end else if ((id >= ID_ILL_LO && id <= ID_ILL_HI) || id > ID_RESET) begin
      cls = CLS_ILLEGAL;
    end else if ((id >= ID_MEM_LO && id <= ID_MEM_HI) || id == ID_MEM_X0 || id == ID_MEM_X1) begin
      cls = CLS_MEM;
    end else if (id == ID_INSW) begin
      cls = CLS_IO;
    end else if (id == ID_HALT) begin
      cls = CLS_HALT;
    end else begin
      cls = CLS_ALU;
    end
    return cls;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// ARM condition-code evaluator: cond field plus NZCV flags -> pass. Purely combinational,
// shared between the sequencer and the decoder.
module cond_eval
  import armaria_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n_s;
  logic z_s;
  logic c_s;
  logic v_s;

  assign n_s = flags[3];
  assign z_s = flags[2];
  assign c_s = flags[1];
  assign v_s = flags[0];

  // Condition table lookup
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z_s;
      COND_NE: pass = ~z_s;
      COND_CS: pass = c_s;
      COND_CC: pass = ~c_s;
      COND_MI: pass = n_s;
      COND_PL: pass = ~n_s;
      COND_VS: pass = v_s;
      COND_VC: pass = ~v_s;
      COND_HI: pass = c_s & ~z_s;
      COND_LS: pass = ~c_s | z_s;
      COND_GE: pass = (n_s == v_s);
      COND_LT: pass = (n_s != v_s);
      COND_GT: pass = ~z_s & (n_s == v_s);
      COND_LE: pass = z_s | (n_s != v_s);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// FETCH/EXEC sequencer feeding the control core; stretches memory, switch-input and halt
// instructions. Define SEQ_WATCHDOG_EN to add the MEM_WAIT timeout watchdog.
module control_sequencer
  import armaria_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES = 4,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [ID_W-1:0] decoded_id,
  input  logic [3:0]      cond,
  input  logic [3:0]      flags,
  input  logic            mem_ready,
  input  logic            io_confirm,
  output logic [ID_W-1:0] id_out,
  output logic            take,
  output logic            ir_load,
  output logic            pc_enable,
  output logic            seq_error
);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
`ifdef SEQ_WATCHDOG_EN
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MEM_TIMEOUT - 1);
`else
  localparam int mem_timeout_unused = MEM_TIMEOUT;
`endif

  seq_state_e      state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [ID_W-1:0]  id_lat_r, id_lat_nxt_s;
  logic [ID_W-1:0]  id_out_r, id_out_nxt_s;
  logic             take_r, take_nxt_s;
  logic             ir_load_r, ir_load_nxt_s;
  logic             pc_enable_r, pc_enable_nxt_s;
  logic             seq_error_r, seq_error_nxt_s;
  logic             io_prev_r;
  logic             io_edge_s;
  logic             pass_s;

  cond_eval u_cond_eval (
    .cond  (cond),
    .flags (flags),
    .pass  (pass_s)
  );

  assign io_edge_s = io_confirm & ~io_prev_r;

  // Next state and next registered outputs. Outputs always describe the state being
  // entered, so a wait state retires through one EXEC cycle carrying pc_enable.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    id_lat_nxt_s    = id_lat_r;
    id_out_nxt_s    = id_out_r;
    take_nxt_s      = take_r;
    ir_load_nxt_s   = 1'b0;
    pc_enable_nxt_s = 1'b0;
    seq_error_nxt_s = seq_error_r;
    case (state_r)
      ST_RST: begin
        id_out_nxt_s = ID_RESET;
        if (cnt_r == RST_LAST) begin
          state_nxt_s   = ST_FETCH;
          cnt_nxt_s     = {CNT_W{1'b0}};
          ir_load_nxt_s = 1'b1;
          id_out_nxt_s  = ID_NOP;
        end else begin
          cnt_nxt_s = cnt_r + 8'd1;
        end
      end
      ST_FETCH: begin
        state_nxt_s  = ST_EXEC;
        id_lat_nxt_s = decoded_id;
        take_nxt_s   = pass_s;
        case (classify_id(decoded_id))
          CLS_ALU: begin
            id_out_nxt_s    = decoded_id;
            pc_enable_nxt_s = 1'b1;
          end
          CLS_ILLEGAL: begin
            id_out_nxt_s    = ID_NOP;
            pc_enable_nxt_s = 1'b1;
            seq_error_nxt_s = 1'b1;
          end
          default: id_out_nxt_s = decoded_id;
        endcase
      end
      ST_EXEC: begin
        if (pc_enable_r) begin
          state_nxt_s   = ST_FETCH;
          ir_load_nxt_s = 1'b1;
          id_out_nxt_s  = ID_NOP;
        end else begin
          case (classify_id(id_lat_r))
            CLS_MEM: begin
              state_nxt_s = ST_MEM_WAIT;
              cnt_nxt_s   = {CNT_W{1'b0}};
            end
            CLS_IO:   state_nxt_s = ST_IO_WAIT;
            CLS_HALT: state_nxt_s = ST_HALT;
            default: begin
              state_nxt_s   = ST_FETCH;
              ir_load_nxt_s = 1'b1;
              id_out_nxt_s  = ID_NOP;
            end
          endcase
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          state_nxt_s     = ST_EXEC;
          pc_enable_nxt_s = 1'b1;
        end else begin
`ifdef SEQ_WATCHDOG_EN
          if (cnt_r == WD_LAST) begin
            state_nxt_s     = ST_HALT;
            id_out_nxt_s    = ID_HALT;
            seq_error_nxt_s = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r + 8'd1;
          end
`else
          state_nxt_s = ST_MEM_WAIT;
`endif
        end
      end
      ST_IO_WAIT, ST_HALT: begin
        if (io_edge_s) begin
          state_nxt_s     = ST_EXEC;
          pc_enable_nxt_s = 1'b1;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s  = ST_RST;
        cnt_nxt_s    = {CNT_W{1'b0}};
        id_out_nxt_s = ID_RESET;
      end
    endcase
  end

  // State and output registers; reset overrides any instruction in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_RST;
      cnt_r       <= {CNT_W{1'b0}};
      id_lat_r    <= ID_RESET;
      id_out_r    <= ID_RESET;
      take_r      <= 1'b0;
      ir_load_r   <= 1'b0;
      pc_enable_r <= 1'b0;
      seq_error_r <= 1'b0;
      io_prev_r   <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      id_lat_r    <= id_lat_nxt_s;
      id_out_r    <= id_out_nxt_s;
      take_r      <= take_nxt_s;
      ir_load_r   <= ir_load_nxt_s;
      pc_enable_r <= pc_enable_nxt_s;
      seq_error_r <= seq_error_nxt_s;
      io_prev_r   <= io_confirm;
    end
  end

  assign id_out    = id_out_r;
  assign take      = take_r;
  assign ir_load   = ir_load_r;
  assign pc_enable = pc_enable_r;
  assign seq_error = seq_error_r;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed, table-driven bench for control_sequencer (default build, RESET_CYCLES=4).
module tb_control_sequencer;

  logic       clock;
  logic       reset;
  logic [6:0] decoded_id;
  logic [3:0] cond;
  logic [3:0] flags;
  logic       mem_ready;
  logic       io_confirm;
  logic [6:0] id_out;
  logic       take;
  logic       ir_load;
  logic       pc_enable;
  logic       seq_error;

  int total;
  int bad;

  typedef struct {
    logic [6:0] id;
    logic [3:0] cnd;
    logic [3:0] flg;
    logic [6:0] exp_id;
    logic       exp_take;
    logic       exp_err;
  } vec_t;

  vec_t vecs[17];

  control_sequencer #(.RESET_CYCLES(4), .MEM_TIMEOUT(255)) dut (
    .clock      (clock),
    .reset      (reset),
    .decoded_id (decoded_id),
    .cond       (cond),
    .flags      (flags),
    .mem_ready  (mem_ready),
    .io_confirm (io_confirm),
    .id_out     (id_out),
    .take       (take),
    .ir_load    (ir_load),
    .pc_enable  (pc_enable),
    .seq_error  (seq_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock and sample just after the edge; also check the pc/ir exclusion.
  task automatic step();
    @(posedge clock);
    #1;
    check("pc_ir_exclusive", int'(pc_enable & ir_load), 0);
  endtask

  task automatic expect_out(input string tag, input int e_id, input int e_ir, input int e_pc);
    check({tag, "_id"}, int'(id_out), e_id);
    check({tag, "_ir"}, int'(ir_load), e_ir);
    check({tag, "_pc"}, int'(pc_enable), e_pc);
  endtask

  // Assert reset for one edge, check reset values, release and follow through to FETCH.
  task automatic reset_seq();
    reset = 1'b1;
    step();
    expect_out("rst", 100, 0, 0);
    check("rst_take", int'(take), 0);
    check("rst_err", int'(seq_error), 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("rst_hold", 100, 0, 0);
    end
    step();
    expect_out("first_fetch", 74, 1, 0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    decoded_id = 7'd0;
    cond = 4'd0;
    flags = 4'd0;
    mem_ready = 1'b0;
    io_confirm = 1'b0;

    vecs[0]  = '{7'd4,   4'd14, 4'b0000, 7'd4,   1'b1, 1'b0};
    vecs[1]  = '{7'd38,  4'd0,  4'b0100, 7'd38,  1'b1, 1'b0};
    vecs[2]  = '{7'd38,  4'd0,  4'b0000, 7'd38,  1'b0, 1'b0};
    vecs[3]  = '{7'd38,  4'd15, 4'b1111, 7'd38,  1'b0, 1'b0};
    vecs[4]  = '{7'd10,  4'd8,  4'b0010, 7'd10,  1'b1, 1'b0};
    vecs[5]  = '{7'd10,  4'd9,  4'b0010, 7'd10,  1'b0, 1'b0};
    vecs[6]  = '{7'd12,  4'd10, 4'b1001, 7'd12,  1'b1, 1'b0};
    vecs[7]  = '{7'd12,  4'd11, 4'b1000, 7'd12,  1'b1, 1'b0};
    vecs[8]  = '{7'd20,  4'd12, 4'b0000, 7'd20,  1'b1, 1'b0};
    vecs[9]  = '{7'd20,  4'd13, 4'b0000, 7'd20,  1'b0, 1'b0};
    vecs[10] = '{7'd100, 4'd1,  4'b0000, 7'd100, 1'b1, 1'b0};
    vecs[11] = '{7'd74,  4'd3,  4'b0010, 7'd74,  1'b0, 1'b0};
    vecs[12] = '{7'd56,  4'd2,  4'b0000, 7'd56,  1'b0, 1'b0};
    vecs[13] = '{7'd90,  4'd14, 4'b0000, 7'd74,  1'b1, 1'b1};
    vecs[14] = '{7'd127, 4'd4,  4'b1000, 7'd74,  1'b1, 1'b1};
    vecs[15] = '{7'd76,  4'd6,  4'b0001, 7'd74,  1'b1, 1'b1};
    vecs[16] = '{7'd0,   4'd7,  4'b0001, 7'd74,  1'b0, 1'b1};

    reset_seq();

    // Single-cycle instructions: EXEC with pc_enable, then FETCH with take held.
    for (int i = 0; i < 17; i++) begin
      decoded_id = vecs[i].id;
      cond = vecs[i].cnd;
      flags = vecs[i].flg;
      step();
      expect_out($sformatf("v%0d_exec", i), int'(vecs[i].exp_id), 0, 1);
      check($sformatf("v%0d_take", i), int'(take), int'(vecs[i].exp_take));
      check($sformatf("v%0d_err", i), int'(seq_error), int'(vecs[i].exp_err));
      decoded_id = 7'd5;
      flags = ~vecs[i].flg;
      step();
      expect_out($sformatf("v%0d_fetch", i), 74, 1, 0);
      check($sformatf("v%0d_take_hold", i), int'(take), int'(vecs[i].exp_take));
    end

    // Memory op: mem_ready during EXEC ignored, three waiting cycles, then one retire.
    decoded_id = 7'd41;
    cond = 4'd14;
    mem_ready = 1'b1;
    step();
    expect_out("mem_exec", 41, 0, 0);
    decoded_id = 7'd5;
    step();
    expect_out("mem_wait0", 41, 0, 0);
    mem_ready = 1'b0;
    step();
    expect_out("mem_wait1", 41, 0, 0);
    step();
    expect_out("mem_wait2", 41, 0, 0);
    mem_ready = 1'b1;
    step();
    expect_out("mem_retire", 41, 0, 1);
    check("err_sticky", int'(seq_error), 1);
    mem_ready = 1'b0;
    step();
    expect_out("mem_fetch", 74, 1, 0);

    // Reset landing in MEM_WAIT
    decoded_id = 7'd67;
    step();
    expect_out("mem2_exec", 67, 0, 0);
    step();
    expect_out("mem2_wait", 67, 0, 0);
    reset_seq();

    // Switch input: waits for a rising edge of io_confirm.
    decoded_id = 7'd71;
    step();
    expect_out("io_exec", 71, 0, 0);
    step();
    expect_out("io_wait0", 71, 0, 0);
    step();
    expect_out("io_wait1", 71, 0, 0);
    io_confirm = 1'b1;
    step();
    expect_out("io_retire", 71, 0, 1);
    step();
    expect_out("io_fetch", 74, 1, 0);
    io_confirm = 1'b0;

    // Halt with the button held since reset: no edge, so it stays halted.
    io_confirm = 1'b1;
    reset_seq();
    decoded_id = 7'd75;
    step();
    expect_out("halt_exec", 75, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out("halt_hold", 75, 0, 0);
    end
    io_confirm = 1'b0;
    step();
    expect_out("halt_low", 75, 0, 0);
    io_confirm = 1'b1;
    step();
    expect_out("halt_retire", 75, 0, 1);
    step();
    expect_out("halt_fetch", 74, 1, 0);
    check("halt_err", int'(seq_error), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
